// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding (also used by the master's debug decode),
// R/W bit values and the default target address.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_RX       = 4'd3,
    ST_RX_ACK   = 4'd4,
    ST_TX       = 4'd5,
    ST_TX_ACK   = 4'd6,
    ST_IGNORE   = 4'd7
  } i2c_state_e;

  localparam logic       I2C_READ         = 1'b1;
  localparam logic       I2C_WRITE        = 1'b0;
  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h2D;

  function automatic logic addr_matches(input logic [7:0] addr_byte, input logic [6:0] addr);
    return addr_byte[7:1] == addr;
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for one bus line, followed by a registered edge detector.
// level/rise/fall are mutually aligned and trail the pin by 3 clk.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync2_q, prev_q, rise_q, fall_q;
  logic sync1_d, sync2_d, prev_d, rise_d, fall_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rise_d  = sync2_q & ~prev_q;
    fall_d  = ~sync2_q & prev_q;
  end

  // The synchronizer keeps tracking the pin through reset so no phantom edge follows release.
  always_ff @(posedge clk) begin
    sync1_q <= sync1_d;
    sync2_q <= sync2_d;
    prev_q  <= prev_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = prev_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target with oversampled SCL/SDA, START/STOP detection and a host byte stream.
// Define I2C_SLAVE_GENERAL_CALL_EN to also accept the general-call write address 8'h00.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = I2C_DEFAULT_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic [3:0] state
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge u_scl (.clk(clk), .rst(rst), .din(scl_in),
                       .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
  i2c_sync_edge u_sda (.clk(clk), .rst(rst), .din(sda_in),
                       .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

  logic start_det, stop_det, addr_hit;
  logic [7:0] rx_byte;

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       sda_out_q, sda_out_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;

  always_comb begin
    start_det = sda_fall & scl_lvl;
    stop_det  = sda_rise & scl_lvl;
    rx_byte   = {shift_q, sda_lvl};
    addr_hit  = addr_matches(rx_byte, SLAVE_ADDR);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
    if (rx_byte == 8'h00) addr_hit = 1'b1;
`endif
  end

  // Bus conditions take priority over any SCL edge seen in the same cycle.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    sda_out_d  = sda_out_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;
    rw_d       = rw_q;

    if (tx_req_q) tx_shift_d = tx_data;

    if (stop_det || start_det) begin
      state_d   = stop_det ? ST_IDLE : ST_ADDR;
      bit_cnt_d = 4'd0;
      sda_out_d = 1'b1;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: if (scl_rise) begin
          shift_d = rx_byte[6:0];
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
            if (addr_hit) begin
              state_d = ST_ADDR_ACK;
              busy_d  = 1'b1;
              rw_d    = rx_byte[0];
            end else begin
              state_d = ST_IGNORE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        // bit_cnt 0 -> waiting for the fall that opens the ACK slot, 1 -> for the one closing it.
        ST_ADDR_ACK: if (scl_fall) begin
          if (bit_cnt_q == 4'd0) begin
            sda_out_d = 1'b0;
            bit_cnt_d = 4'd1;
            tx_req_d  = (rw_q == I2C_READ);
          end else if (rw_q == I2C_READ) begin
            state_d    = ST_TX;
            sda_out_d  = tx_shift_q[7];
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            bit_cnt_d  = 4'd1;
          end else begin
            state_d   = ST_RX;
            sda_out_d = 1'b1;
            bit_cnt_d = 4'd0;
          end
        end
        ST_RX: if (scl_rise) begin
          shift_d = rx_byte[6:0];
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
            if (rx_ready) begin
              rx_data_d  = rx_byte;
              rx_valid_d = 1'b1;
              state_d    = ST_RX_ACK;
            end else begin
              state_d = ST_IGNORE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        ST_RX_ACK: if (scl_fall) begin
          if (bit_cnt_q == 4'd0) begin
            sda_out_d = 1'b0;
            bit_cnt_d = 4'd1;
          end else begin
            state_d   = ST_RX;
            sda_out_d = 1'b1;
            bit_cnt_d = 4'd0;
          end
        end
        ST_TX: if (scl_fall) begin
          if (bit_cnt_q == 4'd8) begin
            state_d   = ST_TX_ACK;
            sda_out_d = 1'b1;
            bit_cnt_d = 4'd0;
          end else begin
            sda_out_d  = tx_shift_q[7];
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            bit_cnt_d  = bit_cnt_q + 4'd1;
          end
        end
        ST_TX_ACK: if (scl_rise) begin
          if (!sda_lvl) begin
            state_d  = ST_TX;
            tx_req_d = 1'b1;
          end else begin
            state_d = ST_IGNORE;
          end
        end
        ST_IGNORE: sda_out_d = 1'b1;
        default:   state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 7'd0;
      tx_shift_q <= 8'd0;
      rx_data_q  <= 8'h00;
      sda_out_q  <= 1'b1;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= I2C_WRITE;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      rx_data_q  <= rx_data_d;
      sda_out_q  <= sda_out_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
    end
  end

  assign sda_out  = sda_out_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;
  assign state    = state_q;

endmodule
